// File: rtl/active_list_pkg.sv
// Shared constants for the in-order retirement buffer.
// Depth, FSM encoding and physical register width helpers.
package active_list_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    ROLLBACK = 1'b1
  } al_state_e;

  function automatic int depth_of(input int idx_w);
    return 1 << idx_w;
  endfunction

  function automatic int paddr_w(input int reg_w);
    return reg_w + 1;
  endfunction

endpackage

// File: rtl/active_list.sv
// Active list: allocates in rename order, retires in order,
// and unwinds uncommitted entries youngest-first on flush.
module active_list
  import active_list_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      alloc_en,
  input  logic [ADDR_WIDTH-1:0]     alloc_pc,
  input  logic                      alloc_wb_reg,
  input  logic [REG_ADDR_WIDTH-1:0] alloc_virtual_addr,
  input  logic [REG_ADDR_WIDTH:0]   alloc_physical_addr,
  input  logic [REG_ADDR_WIDTH:0]   alloc_old_physical_addr,
  output logic                      alloc_ready,
  output logic [FREE_LIST_WIDTH-1:0] alloc_index,
  input  logic                      complete_en,
  input  logic [FREE_LIST_WIDTH-1:0] complete_index,
  output logic                      commit_valid,
  output logic [ADDR_WIDTH-1:0]     commit_pc,
  output logic                      commit_wb_reg,
  output logic [REG_ADDR_WIDTH-1:0] commit_virtual_addr,
  output logic [REG_ADDR_WIDTH:0]   commit_physical_addr,
  output logic [REG_ADDR_WIDTH:0]   commit_old_physical_addr,
  output logic                      rollback_valid,
  output logic                      rollback_wb_reg,
  output logic [REG_ADDR_WIDTH-1:0] rollback_virtual_addr,
  output logic [REG_ADDR_WIDTH:0]   rollback_physical_addr,
  output logic [REG_ADDR_WIDTH:0]   rollback_old_physical_addr,
  output logic                      busy,
  output logic                      full,
  output logic                      empty,
  output logic [FREE_LIST_WIDTH:0]  count
);

  localparam int DEPTH = depth_of(FREE_LIST_WIDTH);
  localparam int PW    = paddr_w(REG_ADDR_WIDTH);
  localparam int IW    = FREE_LIST_WIDTH;
  localparam int CW    = FREE_LIST_WIDTH + 1;

  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [IW-1:0] STEP_C = IW'(1);

  logic [DEPTH-1:0]          valid_q;
  logic [DEPTH-1:0]          done_q;
  logic [ADDR_WIDTH-1:0]     pc_q    [DEPTH];
  logic                      wb_q    [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] vaddr_q [DEPTH];
  logic [PW-1:0]             paddr_q [DEPTH];
  logic [PW-1:0]             opaddr_q[DEPTH];

  logic [IW-1:0] head_q, tail_q, tail_m1;
  logic [CW-1:0] count_q, count_d;
  al_state_e     state_q, state_d;
  logic          full_q, empty_q;

  logic alloc_fire, commit_fire, cpl_fire, rb_fire;

  assign tail_m1     = tail_q - STEP_C;
  assign alloc_ready = !full_q && (state_q == IDLE);
  assign alloc_index = tail_q;
  assign alloc_fire  = alloc_en && alloc_ready && !flush;

  assign commit_fire = (state_q == IDLE) && (count_q != '0) &&
                       valid_q[head_q] && done_q[head_q] && !flush;

  assign cpl_fire = complete_en && (state_q == IDLE) &&
                    valid_q[complete_index] &&
                    !done_q[complete_index];

  assign rb_fire = (state_q == ROLLBACK) && (count_q != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (flush && count_q != '0) state_d = ROLLBACK;
      ROLLBACK:
        if (count_q <= ONE_C) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      rb_fire:                     count_d = count_q - ONE_C;
      alloc_fire && !commit_fire:  count_d = count_q + ONE_C;
      commit_fire && !alloc_fire:  count_d = count_q - ONE_C;
      default: ;
    endcase
  end

  // Status and pointers; payload arrays need no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= (count_d == FULL_C);
      empty_q <= (count_d == '0);
      if (cpl_fire) done_q[complete_index] <= 1'b1;
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + STEP_C;
      end
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + STEP_C;
      end
      if (rb_fire) begin
        valid_q[tail_m1] <= 1'b0;
        done_q[tail_m1]  <= 1'b0;
        tail_q           <= tail_m1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_q]     <= alloc_pc;
      wb_q[tail_q]     <= alloc_wb_reg;
      vaddr_q[tail_q]  <= alloc_virtual_addr;
      paddr_q[tail_q]  <= alloc_physical_addr;
      opaddr_q[tail_q] <= alloc_old_physical_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid               <= 1'b0;
      commit_pc                  <= '0;
      commit_wb_reg              <= 1'b0;
      commit_virtual_addr        <= '0;
      commit_physical_addr       <= '0;
      commit_old_physical_addr   <= '0;
      rollback_valid             <= 1'b0;
      rollback_wb_reg            <= 1'b0;
      rollback_virtual_addr      <= '0;
      rollback_physical_addr     <= '0;
      rollback_old_physical_addr <= '0;
    end else begin
      commit_valid   <= commit_fire;
      rollback_valid <= rb_fire;
      if (commit_fire) begin
        commit_pc                <= pc_q[head_q];
        commit_wb_reg            <= wb_q[head_q];
        commit_virtual_addr      <= vaddr_q[head_q];
        commit_physical_addr     <= paddr_q[head_q];
        commit_old_physical_addr <= opaddr_q[head_q];
      end
      if (rb_fire) begin
        rollback_wb_reg            <= wb_q[tail_m1];
        rollback_virtual_addr      <= vaddr_q[tail_m1];
        rollback_physical_addr     <= paddr_q[tail_m1];
        rollback_old_physical_addr <= opaddr_q[tail_m1];
      end
    end
  end

  assign busy  = (state_q == ROLLBACK);
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: tb/tb_active_list.sv
// Directed bench for active_list: alloc, in-order commit,
// wrap, flush rollback, empty flush, reset mid-rollback.
module tb_active_list;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alloc_en;
  logic [31:0] alloc_pc;
  logic        alloc_wb_reg;
  logic [4:0]  alloc_virtual_addr;
  logic [5:0]  alloc_physical_addr;
  logic [5:0]  alloc_old_physical_addr;
  logic        alloc_ready;
  logic [2:0]  alloc_index;
  logic        complete_en;
  logic [2:0]  complete_index;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_wb_reg;
  logic [4:0]  commit_virtual_addr;
  logic [5:0]  commit_physical_addr;
  logic [5:0]  commit_old_physical_addr;
  logic        rollback_valid;
  logic        rollback_wb_reg;
  logic [4:0]  rollback_virtual_addr;
  logic [5:0]  rollback_physical_addr;
  logic [5:0]  rollback_old_physical_addr;
  logic        busy;
  logic        full;
  logic        empty;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  active_list dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .flush                      (flush),
    .alloc_en                   (alloc_en),
    .alloc_pc                   (alloc_pc),
    .alloc_wb_reg               (alloc_wb_reg),
    .alloc_virtual_addr         (alloc_virtual_addr),
    .alloc_physical_addr        (alloc_physical_addr),
    .alloc_old_physical_addr    (alloc_old_physical_addr),
    .alloc_ready                (alloc_ready),
    .alloc_index                (alloc_index),
    .complete_en                (complete_en),
    .complete_index             (complete_index),
    .commit_valid               (commit_valid),
    .commit_pc                  (commit_pc),
    .commit_wb_reg              (commit_wb_reg),
    .commit_virtual_addr        (commit_virtual_addr),
    .commit_physical_addr       (commit_physical_addr),
    .commit_old_physical_addr   (commit_old_physical_addr),
    .rollback_valid             (rollback_valid),
    .rollback_wb_reg            (rollback_wb_reg),
    .rollback_virtual_addr      (rollback_virtual_addr),
    .rollback_physical_addr     (rollback_physical_addr),
    .rollback_old_physical_addr (rollback_old_physical_addr),
    .busy                       (busy),
    .full                       (full),
    .empty                      (empty),
    .count                      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush                   = 1'b0;
    alloc_en                = 1'b0;
    alloc_pc                = '0;
    alloc_wb_reg            = 1'b0;
    alloc_virtual_addr      = '0;
    alloc_physical_addr     = '0;
    alloc_old_physical_addr = '0;
    complete_en             = 1'b0;
    complete_index          = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_alloc(input int i, input int pa);
    alloc_en                = 1'b1;
    alloc_pc                = 32'h1000 + 32'(i * 4);
    alloc_wb_reg            = 1'b1;
    alloc_virtual_addr      = 5'(i + 1);
    alloc_physical_addr     = 6'(pa);
    alloc_old_physical_addr = 6'(pa - 20);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_rollback_valid", 64'(rollback_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_commit_pa", 64'(commit_physical_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Alloc three entries, none done yet
    for (int i = 0; i < 3; i++) begin
      set_alloc(i, 33 + i);
      chk("t1_alloc_index", 64'(alloc_index), 64'(i));
      step();
    end
    idle_inputs();
    chk("t1_count", 64'(count), 64'd3);
    step();
    chk("t1_no_commit", 64'(commit_valid), 64'd0);

    // Out-of-order completion, in-order commit
    complete_en = 1'b1;
    complete_index = 3'd2;
    step();
    chk("t2_no_commit_a", 64'(commit_valid), 64'd0);
    complete_index = 3'd0;
    step();
    chk("t2_no_commit_b", 64'(commit_valid), 64'd0);
    complete_index = 3'd1;
    step();
    chk("t2_commit0_v", 64'(commit_valid), 64'd1);
    chk("t2_commit0_pa", 64'(commit_physical_addr), 64'd33);
    chk("t2_commit0_pc", 64'(commit_pc), 64'h1000);
    chk("t2_commit0_opa", 64'(commit_old_physical_addr), 64'd13);
    idle_inputs();
    step();
    chk("t2_commit1_v", 64'(commit_valid), 64'd1);
    chk("t2_commit1_pa", 64'(commit_physical_addr), 64'd34);
    step();
    chk("t2_commit2_v", 64'(commit_valid), 64'd1);
    chk("t2_commit2_pa", 64'(commit_physical_addr), 64'd35);
    chk("t2_commit2_va", 64'(commit_virtual_addr), 64'd3);
    chk("t2_empty", 64'(empty), 64'd1);
    chk("t2_count", 64'(count), 64'd0);
    step();
    chk("t2_commit_end", 64'(commit_valid), 64'd0);

    // Fill to full, overflow ignored, commit then wrap
    do_reset();
    step();
    for (int i = 0; i < 8; i++) begin
      set_alloc(i, 40 + i);
      chk("t3_alloc_index", 64'(alloc_index), 64'(i));
      step();
    end
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_count8", 64'(count), 64'd8);
    chk("t3_not_ready", 64'(alloc_ready), 64'd0);
    chk("t3_tail_wrap", 64'(alloc_index), 64'd0);
    set_alloc(8, 60);
    step();
    chk("t3_ovf_count", 64'(count), 64'd8);
    chk("t3_ovf_tail", 64'(alloc_index), 64'd0);
    idle_inputs();
    complete_en = 1'b1;
    complete_index = 3'd0;
    step();
    idle_inputs();
    step();
    chk("t3_commit_v", 64'(commit_valid), 64'd1);
    chk("t3_commit_pa", 64'(commit_physical_addr), 64'd40);
    chk("t3_count7", 64'(count), 64'd7);
    chk("t3_not_full", 64'(full), 64'd0);
    chk("t3_ready", 64'(alloc_ready), 64'd1);
    chk("t3_wrap_index", 64'(alloc_index), 64'd0);
    set_alloc(9, 50);
    step();
    idle_inputs();
    chk("t3_refill_count", 64'(count), 64'd8);
    chk("t3_refill_full", 64'(full), 64'd1);
    chk("t3_tail_next", 64'(alloc_index), 64'd1);

    // Flush against a commit-eligible head
    do_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      set_alloc(i, 60 + i);
      step();
    end
    idle_inputs();
    complete_en = 1'b1;
    complete_index = 3'd0;
    step();
    complete_en = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_no_commit_flush", 64'(commit_valid), 64'd0);
    chk("t4_busy0", 64'(busy), 64'd1);
    chk("t4_rb_idle0", 64'(rollback_valid), 64'd0);
    step();
    chk("t4_rb2_v", 64'(rollback_valid), 64'd1);
    chk("t4_rb2_pa", 64'(rollback_physical_addr), 64'd62);
    chk("t4_rb2_opa", 64'(rollback_old_physical_addr), 64'd42);
    chk("t4_rb2_va", 64'(rollback_virtual_addr), 64'd3);
    chk("t4_rb2_wb", 64'(rollback_wb_reg), 64'd1);
    chk("t4_busy1", 64'(busy), 64'd1);
    chk("t4_count2", 64'(count), 64'd2);
    chk("t4_no_commit_a", 64'(commit_valid), 64'd0);
    step();
    chk("t4_rb1_v", 64'(rollback_valid), 64'd1);
    chk("t4_rb1_pa", 64'(rollback_physical_addr), 64'd61);
    chk("t4_busy2", 64'(busy), 64'd1);
    chk("t4_no_commit_b", 64'(commit_valid), 64'd0);
    step();
    chk("t4_rb0_v", 64'(rollback_valid), 64'd1);
    chk("t4_rb0_pa", 64'(rollback_physical_addr), 64'd60);
    chk("t4_busy_done", 64'(busy), 64'd0);
    chk("t4_count0", 64'(count), 64'd0);
    chk("t4_no_commit_c", 64'(commit_valid), 64'd0);
    step();
    chk("t4_rb_end", 64'(rollback_valid), 64'd0);
    chk("t4_empty", 64'(empty), 64'd1);
    chk("t4_head_eq_tail", 64'(alloc_index), 64'd0);

    // Flush of an empty list
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rb", 64'(rollback_valid), 64'd0);
    chk("t5_ready", 64'(alloc_ready), 64'd1);
    set_alloc(0, 7);
    step();
    idle_inputs();
    chk("t5_count", 64'(count), 64'd1);
    step();
    chk("t5_rb_after", 64'(rollback_valid), 64'd0);

    // Reset in the middle of a rollback
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      set_alloc(i, 20 + i);
      step();
    end
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("t6_rb_first", 64'(rollback_valid), 64'd1);
    chk("t6_rb_first_pa", 64'(rollback_physical_addr), 64'd23);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rb", 64'(rollback_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_empty", 64'(empty), 64'd1);
    chk("t6_rst_rb_pa", 64'(rollback_physical_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_rb", 64'(rollback_valid), 64'd0);
      chk("t6_idle", 64'(busy), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/active_list.md
Name: active_list

Overview:
In-order retirement buffer for the renamed pipeline. It sits beside decode/rename and feeds the `active_list_index_in` input of the decode-to-execute register. It allocates one entry per renamed instruction and marks entries done on writeback completion. It retires at most one entry per cycle in program order, releasing the superseded physical register. On flush it rolls back uncommitted entries youngest-first so rename map and free list can be restored.

Parameters:
ADDR_WIDTH, 32, PC width
REG_ADDR_WIDTH, 5, architectural register address width; physical address is REG_ADDR_WIDTH+1 bits
FREE_LIST_WIDTH, 3, index width; DEPTH = 2**FREE_LIST_WIDTH entries (8)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  squash all uncommitted entries
alloc_en  in  1  allocate entry this cycle
alloc_pc  in  ADDR_WIDTH  instruction PC
alloc_wb_reg  in  1  instruction writes a register
alloc_virtual_addr  in  REG_ADDR_WIDTH  architectural destination
alloc_physical_addr  in  REG_ADDR_WIDTH+1  new physical destination
alloc_old_physical_addr  in  REG_ADDR_WIDTH+1  previous mapping of destination
alloc_ready  out  1  entry available (= !full && state==IDLE)
alloc_index  out  FREE_LIST_WIDTH  index granted (= tail), combinational
complete_en  in  1  writeback done
complete_index  in  FREE_LIST_WIDTH  entry completed
commit_valid  out  1  registered one-cycle retire pulse
commit_pc, commit_wb_reg, commit_virtual_addr, commit_physical_addr, commit_old_physical_addr  out  widths as alloc_*  retired entry fields, registered
rollback_valid  out  1  registered one-cycle squash pulse
rollback_wb_reg, rollback_virtual_addr, rollback_physical_addr, rollback_old_physical_addr  out  widths as alloc_*  squashed entry fields, registered
busy  out  1  rollback in progress
full, empty  out  1  registered status
count  out  FREE_LIST_WIDTH+1  occupied entries

Behaviour:
- Reset (async, `rst_n` low):
  - head=tail=0, count=0, all valid/done bits 0, state IDLE.
  - Every registered output is 0, except `empty`=1.
- Storage: circular buffer. head/tail wrap modulo DEPTH. count disambiguates full/empty.
- Alloc:
  - Accepted when `alloc_en && alloc_ready && !flush`.
  - Writes fields, sets valid=1 and done=0, increments tail.
  - Alloc without `alloc_ready`: ignored, no state change.
- Complete:
  - When `complete_en` and the entry is valid: sets done=1.
  - Complete to an invalid entry, to an already-done entry, or during ROLLBACK: ignored.
- Commit (IDLE only):
  - Condition: count>0, head entry done, `!flush`.
  - Effect: head entry cleared, head incremented, commit_* registered from the entry, `commit_valid`=1 next cycle.
  - Latency: `complete_en` in cycle N → earliest `commit_valid` in cycle N+2. No bypass.
- Simultaneous alloc and commit in one cycle: count unchanged. Alloc is still gated by the registered `full`, so a full list cannot alloc in the same cycle it commits.
- FSM:
  - IDLE→ROLLBACK on flush when count>0. Flush with count==0: stay IDLE, no rollback pulses.
  - ROLLBACK, one entry per cycle:
    - tail decrements.
    - The entry at new tail is invalidated and its fields are registered to rollback_*.
    - `rollback_valid`=1 on the following cycle.
  - ROLLBACK→IDLE when count reaches 0. Afterwards head==tail; they are not reset to 0.
  - `busy`=1 whenever state==ROLLBACK.
  - In ROLLBACK: flush, alloc, complete are ignored; commit is suppressed.
- Flush in the same cycle as a commit-eligible head: no commit; the head entry is rolled back.
- Reset mid-rollback: immediate return to the reset state; pending rollbacks are lost.
- `commit_valid` and `rollback_valid` are never high together.

Decomposition:
- Shared constants header: DEPTH derived from FREE_LIST_WIDTH, FSM state encodings (IDLE=0, ROLLBACK=1), physical-address width expression.
- No sub-module. Entry storage is flat register arrays (valid, done, pc, wb_reg, vaddr, paddr, old_paddr) inside the block.

Test Plan:
1. Reset, alloc 3 entries with `alloc_physical_addr` 33, 34, 35 → `alloc_index` 0, 1, 2; count=3; `commit_valid` stays 0 (none done).
2. Complete idx 2, then 0, then 1 on consecutive cycles → commits in order 0, 1, 2 on consecutive cycles; `commit_physical_addr` 33, 34, 35; `empty`=1 after.
3. Alloc 8 → `full`=1, `alloc_ready`=0, 9th alloc ignored. Complete head and alloc once the slot frees → tail wraps to 0; count returns to 8.
4. Entries 0..2 allocated, idx 0 done, flush → `rollback_valid` for idx 2, 1, 0 (youngest first) on 3 consecutive cycles; `busy` high for 3 cycles; no `commit_valid`; count=0.
5. Flush with an empty list → `busy` stays 0; no rollback pulses; the next-cycle alloc is accepted.
6. `rst_n` low after the first rollback pulse of a 4-entry flush → all outputs immediately 0 (`empty`=1); no further rollback pulses after release.
